// File: rtl/port_rd_ctrl_pkg.sv
// Shared definitions for the port read controller and the queue scheduler:
// queue count, the "no readable queue" code, and the controller FSM encoding.
package port_rd_ctrl_pkg;

  localparam int         NUM_QUEUES = 4;
  localparam int         QID_W      = $clog2(NUM_QUEUES);
  localparam logic [2:0] PRIOR_NONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_REQ,
    ST_XFER,
    ST_UPD,
    ST_SETTLE_WAIT
  } state_e;

  // Codes 5-7 are never produced by the scheduler; treat them like PRIOR_NONE.
  function automatic logic is_queue_id(input logic [2:0] prior);
    return prior < PRIOR_NONE;
  endfunction

endpackage

// File: rtl/port_rd_ctrl_if.sv
// Bundle of scheduler, queue-manager and egress signals around the read controller.
// master = the controller, slave = its environment.
interface port_rd_ctrl_if #(
  parameter int DATA_W = 16
) ();

  logic [2:0]                           prior_next;
  logic                                 prior_update;
  logic                                 rd_req;
  logic [port_rd_ctrl_pkg::QID_W-1:0]   rd_qid;
  logic                                 rd_gnt;
  logic                                 rd_vld;
  logic [DATA_W-1:0]                    rd_data;
  logic                                 rd_last;
  logic                                 rd_pause;
  logic                                 out_valid;
  logic [DATA_W-1:0]                    out_data;
  logic                                 out_last;
  logic                                 out_ready;
  logic                                 ovf;

  modport master (
    input  prior_next, rd_gnt, rd_vld, rd_data, rd_last, out_ready,
    output prior_update, rd_req, rd_qid, rd_pause, out_valid, out_data, out_last, ovf
  );

  modport slave (
    output prior_next, rd_gnt, rd_vld, rd_data, rd_last, out_ready,
    input  prior_update, rd_req, rd_qid, rd_pause, out_valid, out_data, out_last, ovf
  );

endinterface

// File: rtl/port_rd_fifo.sv
// First-word fall-through skid FIFO. A push while full is taken only when a pop
// frees the head slot in the same cycle; otherwise the caller sees full_o and drops.
module port_rd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/port_rd_ctrl.sv
// Port read controller: picks the scheduler's queue, requests one packet from the
// queue manager, streams it into a skid FIFO toward egress, then reports and settles.
module port_rd_ctrl
  import port_rd_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  port_rd_ctrl_if.master bus
);

  localparam int CNT_W = ($clog2(SETTLE + 1) > 3) ? $clog2(SETTLE + 1) : 3;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [QID_W-1:0]   rd_qid_q, rd_qid_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic               ovf_q, ovf_d;

  logic               word_in;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W:0]    fifo_head;
  logic [OCC_W-1:0]   fifo_count;

  // Words are only accepted while a granted packet is being transferred.
  assign word_in  = (state_q == ST_XFER) && bus.rd_vld;
  assign fifo_pop = !fifo_empty && bus.out_ready;

  port_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (word_in),
    .data_i  ({bus.rd_last, bus.rd_data}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    rd_qid_d     = rd_qid_q;
    settle_cnt_d = settle_cnt_q;
    // A word is lost only if the FIFO is full and no pop frees a slot this cycle.
    ovf_d        = ovf_q | (word_in && fifo_full && !fifo_pop);

    case (state_q)
      ST_IDLE: state_d = ST_SEL;
      ST_SEL: begin
        if (is_queue_id(bus.prior_next)) begin
          rd_qid_d = bus.prior_next[QID_W-1:0];
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.rd_gnt) state_d = ST_XFER;
      end
      ST_XFER: begin
        // The end of packet is honoured even when its word was dropped.
        if (bus.rd_vld && bus.rd_last) state_d = ST_UPD;
      end
      ST_UPD: begin
        settle_cnt_d = '0;
        state_d      = ST_SETTLE_WAIT;
      end
      ST_SETTLE_WAIT: begin
        if (settle_cnt_q == CNT_W'(SETTLE - 1)) state_d = ST_SEL;
        else settle_cnt_d = settle_cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_qid_q     <= '0;
      settle_cnt_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_qid_q     <= rd_qid_d;
      settle_cnt_q <= settle_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.rd_req       = (state_q == ST_REQ);
  assign bus.rd_qid       = rd_qid_q;
  assign bus.prior_update = (state_q == ST_UPD);
  assign bus.rd_pause     = (fifo_count >= OCC_W'(FIFO_DEPTH - 1));
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_head[DATA_W-1:0];
  assign bus.out_last     = fifo_head[DATA_W];
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_port_rd_ctrl.sv
// Directed bench for port_rd_ctrl: selection, handshake, FIFO flow control,
// overflow, settle timing and mid-packet reset, checked with immediate assertions.
module tb_port_rd_ctrl;
  import port_rd_ctrl_pkg::*;

  localparam int DW         = 16;
  localparam int DEPTH      = 4;
  localparam int SETTLE_CYC = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   ovf_exp      = 1'b0;

  port_rd_ctrl_if #(.DATA_W(DW)) bif ();

  port_rd_ctrl #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .SETTLE     (SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic vld, input logic [DW-1:0] data, input logic last);
    bif.rd_vld  = vld;
    bif.rd_data = data;
    bif.rd_last = last;
  endtask

  task automatic wait_sel();
    for (int i = 0; i < 20 && dut.state_q != ST_SEL; i++) tick();
    check("wait_sel", dut.state_q, ST_SEL);
  endtask

  // Select qid and grant in the same cycle rd_req is seen; leaves FSM in XFER.
  task automatic start_packet(input logic [2:0] qid);
    wait_sel();
    bif.prior_next = qid;
    tick();
    check("start_rd_req", bif.rd_req, 1'b1);
    check("start_rd_qid", bif.rd_qid, qid[1:0]);
    bif.prior_next = PRIOR_NONE;
    bif.rd_gnt     = 1'b1;
    tick();
    bif.rd_gnt = 1'b0;
  endtask

  // Streams n words with a small occupancy/order model; egress stalls until ready_after.
  task automatic run_packet(input int n, input bit honor, input int ready_after,
                            input logic [DW-1:0] base);
    logic [DW:0] q[$];
    logic [DW:0] w;
    int occ = 0, sent = 0, cyc = 0;
    bit pu_next = 1'b0, pu_seen = 1'b0, pop, push;
    while (!(sent == n && occ == 0 && pu_seen) && cyc < 300) begin
      bif.out_ready = (cyc >= ready_after);
      check("prior_update", bif.prior_update, pu_next);
      if (pu_next) pu_seen = 1'b1;
      check("out_valid", bif.out_valid, occ > 0);
      check("rd_pause", bif.rd_pause, occ >= DEPTH - 1);
      check("occupancy", dut.fifo_count, occ);
      check("ovf", bif.ovf, ovf_exp);
      if (occ > 0) begin
        check("out_data", bif.out_data, q[0][DW-1:0]);
        check("out_last", bif.out_last, q[0][DW]);
      end
      pop     = (occ > 0) && bif.out_ready;
      push    = 1'b0;
      pu_next = 1'b0;
      if (sent < n && (!honor || !bif.rd_pause)) begin
        w = {sent == n - 1, base + DW'(sent)};
        drive_word(1'b1, w[DW-1:0], w[DW]);
        sent++;
        if (occ < DEPTH || pop) begin
          q.push_back(w);
          push = 1'b1;
        end else begin
          ovf_exp = 1'b1;
        end
        if (w[DW]) pu_next = 1'b1;
      end else begin
        drive_word(1'b0, '0, 1'b0);
      end
      if (pop) void'(q.pop_front());
      occ = occ + int'(push) - int'(pop);
      tick();
      cyc++;
    end
    check("packet_done", (sent == n && occ == 0 && pu_seen), 1'b1);
    drive_word(1'b0, '0, 1'b0);
    bif.out_ready = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bif.prior_next = PRIOR_NONE;
    bif.rd_gnt     = 1'b0;
    bif.out_ready  = 1'b1;
    drive_word(1'b0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    check("rst_rd_req", bif.rd_req, 1'b0);
    check("rst_prior_update", bif.prior_update, 1'b0);
    check("rst_out_valid", bif.out_valid, 1'b0);
    check("rst_out_last", bif.out_last, 1'b0);
    check("rst_ovf", bif.ovf, 1'b0);
    check("rst_rd_pause", bif.rd_pause, 1'b0);
    check("rst_rd_qid", bif.rd_qid, 2'd0);
    check("rst_state", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("first_sel", dut.state_q, ST_SEL);

    // Basic packet: queue 2, grant one cycle after rd_req, 3 words, egress ready
    bif.prior_next = 3'd2;
    tick();
    check("t1_rd_req", bif.rd_req, 1'b1);
    check("t1_rd_qid", bif.rd_qid, 2'd2);
    bif.prior_next = PRIOR_NONE;
    tick();
    check("t1_rd_req_hold", bif.rd_req, 1'b1);
    check("t1_rd_qid_hold", bif.rd_qid, 2'd2);
    bif.rd_gnt = 1'b1;
    tick();
    bif.rd_gnt = 1'b0;
    check("t1_rd_req_xfer", bif.rd_req, 1'b0);
    check("t1_state_xfer", dut.state_q, ST_XFER);
    drive_word(1'b1, 16'hA001, 1'b0);
    tick();
    check("t1_w1_valid", bif.out_valid, 1'b1);
    check("t1_w1_data", bif.out_data, 16'hA001);
    check("t1_w1_last", bif.out_last, 1'b0);
    drive_word(1'b1, 16'hA002, 1'b0);
    tick();
    check("t1_w2_data", bif.out_data, 16'hA002);
    check("t1_w2_pu", bif.prior_update, 1'b0);
    drive_word(1'b1, 16'hA003, 1'b1);
    tick();
    drive_word(1'b0, '0, 1'b0);
    check("t1_w3_data", bif.out_data, 16'hA003);
    check("t1_w3_last", bif.out_last, 1'b1);
    check("t1_pu_pulse", bif.prior_update, 1'b1);
    for (int i = 0; i < SETTLE_CYC; i++) begin
      tick();
      check("t1_settle_state", dut.state_q, ST_SETTLE_WAIT);
      check("t1_settle_pu", bif.prior_update, 1'b0);
      check("t1_settle_empty", bif.out_valid, 1'b0);
    end
    tick();
    check("t1_next_sel", dut.state_q, ST_SEL);

    // No readable queue for 10 cycles, then queue 1
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_idle_rd_req", bif.rd_req, 1'b0);
    end
    bif.prior_next = 3'd1;
    tick();
    check("t2_rd_req", bif.rd_req, 1'b1);
    check("t2_rd_qid", bif.rd_qid, 2'd1);
    bif.prior_next = PRIOR_NONE;
    bif.rd_gnt     = 1'b1;
    tick();
    bif.rd_gnt = 1'b0;

    // 8 words, egress stalled, source honours rd_pause
    run_packet(8, 1'b1, 10, 16'hB000);
    check("t3_no_ovf", bif.ovf, 1'b0);

    // 6 words, egress stalled, source ignores rd_pause
    start_packet(3'd3);
    run_packet(6, 1'b0, 8, 16'hC000);
    check("t4_ovf", bif.ovf, 1'b1);
    tick();
    tick();
    check("t4_ovf_sticky", bif.ovf, 1'b1);

    // Reset during the 2nd of 4 words
    start_packet(3'd3);
    bif.out_ready = 1'b0;
    drive_word(1'b1, 16'hD001, 1'b0);
    tick();
    check("t6_w1_valid", bif.out_valid, 1'b1);
    drive_word(1'b1, 16'hD002, 1'b0);
    rst_n = 1'b0;
    tick();
    drive_word(1'b0, '0, 1'b0);
    ovf_exp = 1'b0;
    check("t6_out_valid", bif.out_valid, 1'b0);
    check("t6_out_last", bif.out_last, 1'b0);
    check("t6_rd_req", bif.rd_req, 1'b0);
    check("t6_pu", bif.prior_update, 1'b0);
    check("t6_ovf", bif.ovf, 1'b0);
    check("t6_rd_pause", bif.rd_pause, 1'b0);
    check("t6_rd_qid", bif.rd_qid, 2'd0);
    check("t6_state_idle", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    check("t6_state_sel", dut.state_q, ST_SEL);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_pu", bif.prior_update, 1'b0);
      check("t6_no_data", bif.out_valid, 1'b0);
    end

    // FIFO full with simultaneous push and pop
    start_packet(3'd0);
    run_packet(6, 1'b0, 4, 16'hE000);
    check("t5_no_ovf", bif.ovf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/port_rd_ctrl.md
PORT_RD_CTRL -- requirements
Module: port_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of the packet data word.
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the output skid FIFO (power of 2, ≥4).
REQ-003 Parameter SETTLE, default 6, cycles to wait after prior_update before sampling prior_next.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 prior_next  in  3  scheduler's chosen queue: 0-3 = queue ID, 4 = no readable queue.
REQ-007 prior_update  out  1  one-cycle pulse telling the scheduler that a packet from prior_next was consumed.
REQ-008 rd_req  out  1  request to the queue manager to start reading one packet.
REQ-009 rd_qid  out  2  queue ID for rd_req.
REQ-010 rd_gnt  in  1  queue manager accepts rd_req in this cycle.
REQ-011 rd_vld  in  1  packet word valid from the queue manager.
REQ-012 rd_data  in  DATA_W  packet word.
REQ-013 rd_last  in  1  marks the last word of the packet.
REQ-014 rd_pause  out  1  source must not assert rd_vld while this is high.
REQ-015 out_valid  out  1  egress word valid.
REQ-016 out_data  out  DATA_W  egress word.
REQ-017 out_last  out  1  egress end-of-packet.
REQ-018 out_ready  in  1  egress accepts the word when out_valid && out_ready.
REQ-019 ovf  out  1  sticky flag: a word arrived while the FIFO was full.

Function
REQ-020 FSM states: IDLE, SEL, REQ, XFER, UPD, SETTLE_WAIT.
REQ-021 IDLE -> SEL unconditionally. Out of reset, SEL is entered after one IDLE cycle.
REQ-022 SEL samples prior_next: a value of 4 keeps the FSM in SEL and re-samples every cycle; a value of 0-3 latches rd_qid = prior_next[1:0] and moves to REQ.
REQ-023 REQ holds rd_req high with a stable rd_qid until rd_gnt, then moves to XFER. rd_req is low in every other state.
REQ-024 XFER pushes each word with rd_vld && !full into the FIFO, as {rd_last, rd_data}.
  - On the push with rd_last=1, the FSM moves to UPD.
REQ-025 UPD drives prior_update=1 for exactly one cycle, then moves to SETTLE_WAIT.
REQ-026 SETTLE_WAIT counts SETTLE cycles, then moves to SEL.
  - The counter is 3 bits or wider, cleared on entry.
REQ-027 rd_pause = (FIFO occupancy ≥ FIFO_DEPTH-1), combinational from the registered count.
REQ-028 rd_vld while the FIFO is full is dropped (no push) and sets ovf=1.
  - ovf clears only on reset.
  - If that dropped word carries rd_last, the FSM still moves to UPD.
REQ-029 rd_vld outside XFER is ignored. No push, no ovf.
REQ-030 out_valid = FIFO not empty; out_data/out_last come from the head entry (first-word fall-through).
  - Pop on out_valid && out_ready.
REQ-031 A simultaneous push and pop leaves the occupancy unchanged, including when the FIFO is full (the pop frees the slot in the same cycle).
REQ-032 Read and write pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-033 A packet in flight in the FIFO does not block the next selection. The FSM may start the next packet while the egress is still draining.
REQ-034 Latency: a word pushed at cycle t is visible on out_* at cycle t+1.

Reset
REQ-035 On rst_n=0 at a clock edge, the block SHALL take these values:
  - FSM = IDLE.
  - FIFO pointers and count = 0.
  - SETTLE counter = 0.
  - rd_qid = 0.
  - Outputs rd_req, prior_update, out_valid, out_last, ovf = 0; rd_pause = 0.
REQ-036 Reset mid-packet discards FIFO contents and the partial packet, and issues no prior_update.

Structure
REQ-037 A shared package holds the following; queue-count and NONE constants are shared with the scheduler:
  - constant NUM_QUEUES=4.
  - constant PRIOR_NONE=3'd4.
  - FSM state encoding.
REQ-038 The FIFO is a separate sub-module, port_rd_fifo (parameters DATA_W+1, FIFO_DEPTH; push/pop/full/empty/count), instantiated once.

Verification
REQ-039 prior_next=2, rd_gnt one cycle after rd_req, 3-word packet, out_ready=1:
  - rd_qid=2.
  - Words appear on out_* one cycle after each push.
  - prior_update pulses once, one cycle after the last push.
  - Next SEL occurs 6 cycles later.
REQ-040 prior_next=4 held for 10 cycles, then 1:
  - rd_req stays 0 for those 10 cycles.
  - rd_req rises with rd_qid=1 the cycle after the value 1 is sampled.
REQ-041 out_ready=0, source honors rd_pause, 8-word packet, FIFO_DEPTH=4:
  - rd_pause asserts at occupancy 3.
  - No ovf.
  - All 8 words exit in order after out_ready=1.
REQ-042 out_ready=0, source ignores rd_pause, 6 words:
  - 4 stored.
  - ovf=1 on the 5th word and remains 1.
  - The last word still produces prior_update.
REQ-043 Reset asserted during XFER of the 2nd of 4 words:
  - All outputs 0 the next cycle.
  - No prior_update.
  - After release, FSM is in IDLE and then SEL.
REQ-044 FIFO full, out_ready=1, rd_vld=1 in the same cycle: occupancy stays at FIFO_DEPTH, ovf stays 0, and words are delivered in order.
